// File: rtl/lvds_rx_buf_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | lvds_rx_buf_arbiter_pkg : constants shared with the LVDS AHB bridge |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lvds_rx_buf_arbiter_pkg;

   localparam int LVDS_NUM_EU        = 4;
   localparam int ST_DONE            = 0;
   localparam int ST_OVF             = 1;
   localparam int ST_BUSY            = 2;
   localparam int BUF_ADDR_W_DEFAULT = 9;
   localparam logic [31:0] EU_BYTE_OFFSET = 32'h0000_0800;

   typedef logic [7:0] eu_state_t;

   function automatic eu_state_t state_byte(input logic done, input logic ovf, input logic busy);
      eu_state_t s;
      s          = '0;
      s[ST_DONE] = done;
      s[ST_OVF]  = ovf;
      s[ST_BUSY] = busy;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_rx_buf_arbiter_rr_arbiter4.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter4 : combinational 4-way round-robin, search from last+1   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] gnt,
   output logic       valid
);

   logic [1:0] idx;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = '0;
      // i = 4 wraps back to 'last' itself, so it gets the lowest priority
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lvds_rx_buf_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | lvds_rx_buf_arbiter : EU receive-buffer write arbiter, pointers and |
// | per-EU state bytes.  rev 1.0                                        |
// +--------------------------------------------------------------------+
module lvds_rx_buf_arbiter
   import lvds_rx_buf_arbiter_pkg::*;
#(
   parameter int BUF_ADDR_W = BUF_ADDR_W_DEFAULT
) (
   input  logic                            HCLK,
   input  logic                            HRESET,
   input  logic [3:0]                      EU_WR_REQ,
   input  logic [127:0]                    EU_WR_DATA,
   input  logic [3:0]                      EU_WR_LAST,
   output logic [3:0]                      EU_WR_ACK,
   output logic [3:0]                      BUF_WE,
   output logic [BUF_ADDR_W-1:0]           BUF_WADDR,
   output logic [31:0]                     BUF_WDATA,
   input  logic                            RX_STATE_CLEAR,
   input  logic [3:0]                      LVDS_EU,
   output logic [7:0]                      LVDS_EU1_STATE,
   output logic [7:0]                      LVDS_EU2_STATE,
   output logic [7:0]                      LVDS_EU3_STATE,
   output logic [7:0]                      LVDS_EU4_STATE,
   output logic [4*(BUF_ADDR_W+1)-1:0]     EU_WCNT
);

   localparam int PW    = BUF_ADDR_W + 1;
   localparam int DEPTH = 1 << BUF_ADDR_W;

   logic [LVDS_NUM_EU-1:0][PW-1:0] wptr_q, wptr_d;
   logic [LVDS_NUM_EU-1:0]         done_q, done_d;
   logic [LVDS_NUM_EU-1:0]         ovf_q, ovf_d;
   eu_state_t [LVDS_NUM_EU-1:0]    state_q, state_d;
   logic [1:0]                     last_grant_q, last_grant_d;
   logic [3:0]                     ack_q, ack_d;
   logic [3:0]                     we_q, we_d;
   logic [BUF_ADDR_W-1:0]          waddr_q, waddr_d;
   logic [31:0]                    wdata_q, wdata_d;

   logic [3:0] w_clr;
   logic [3:0] w_elig;
   logic [3:0] w_gnt;
   logic       w_gnt_valid;

   // ack_q doubles as "granted last cycle", which enforces 1 word per 2 cycles per EU
   assign w_clr  = {4{RX_STATE_CLEAR}} & LVDS_EU;
   assign w_elig = EU_WR_REQ & ~ack_q & ~w_clr;

   rr_arbiter4 u_arb (
      .req   (w_elig),
      .last  (last_grant_q),
      .gnt   (w_gnt),
      .valid (w_gnt_valid)
   );

   always_comb begin
      wptr_d       = wptr_q;
      done_d       = done_q;
      ovf_d        = ovf_q;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      we_d         = '0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      state_d      = state_q;

      for (int k = 0; k < LVDS_NUM_EU; k++) begin
         if (w_gnt_valid && w_gnt[k]) begin
            ack_d[k]     = 1'b1;
            last_grant_d = 2'(k);
            if (!done_q[k] && (wptr_q[k] < PW'(DEPTH))) begin
               we_d[k]   = 1'b1;
               waddr_d   = wptr_q[k][BUF_ADDR_W-1:0];
               wdata_d   = EU_WR_DATA[32*k +: 32];
               wptr_d[k] = wptr_q[k] + PW'(1);
               if (EU_WR_LAST[k]) done_d[k] = 1'b1;
            end else begin
               // frame already closed or buffer full: swallow the word
               ovf_d[k] = 1'b1;
               if (!done_q[k] && EU_WR_LAST[k]) done_d[k] = 1'b1;
            end
         end
      end

      // clear wins over a same-cycle pointer update
      for (int k = 0; k < LVDS_NUM_EU; k++) begin
         if (w_clr[k]) begin
            wptr_d[k] = '0;
            done_d[k] = 1'b0;
            ovf_d[k]  = 1'b0;
         end
         state_d[k] = state_byte(done_d[k], ovf_d[k], (wptr_d[k] != '0) && !done_d[k]);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wptr_q       <= '0;
         done_q       <= '0;
         ovf_q        <= '0;
         state_q      <= '0;
         last_grant_q <= 2'd3;
         ack_q        <= '0;
         we_q         <= '0;
         waddr_q      <= '0;
         wdata_q      <= '0;
      end else begin
         wptr_q       <= wptr_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign EU_WR_ACK      = ack_q;
   assign BUF_WE         = we_q;
   assign BUF_WADDR      = waddr_q;
   assign BUF_WDATA      = wdata_q;
   assign LVDS_EU1_STATE = state_q[0];
   assign LVDS_EU2_STATE = state_q[1];
   assign LVDS_EU3_STATE = state_q[2];
   assign LVDS_EU4_STATE = state_q[3];
   assign EU_WCNT        = wptr_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_buf_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lvds_rx_buf_arbiter : scoreboard bench for lvds_rx_buf_arbiter   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lvds_rx_buf_arbiter;

   localparam int AW = 9;
   localparam int PW = AW + 1;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [3:0]    EU_WR_REQ;
   logic [127:0]  EU_WR_DATA;
   logic [3:0]    EU_WR_LAST;
   logic [3:0]    EU_WR_ACK;
   logic [3:0]    BUF_WE;
   logic [AW-1:0] BUF_WADDR;
   logic [31:0]   BUF_WDATA;
   logic          RX_STATE_CLEAR;
   logic [3:0]    LVDS_EU;
   logic [7:0]    LVDS_EU1_STATE, LVDS_EU2_STATE, LVDS_EU3_STATE, LVDS_EU4_STATE;
   logic [4*PW-1:0] EU_WCNT;

   lvds_rx_buf_arbiter #(.BUF_ADDR_W(AW)) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .EU_WR_REQ      (EU_WR_REQ),
      .EU_WR_DATA     (EU_WR_DATA),
      .EU_WR_LAST     (EU_WR_LAST),
      .EU_WR_ACK      (EU_WR_ACK),
      .BUF_WE         (BUF_WE),
      .BUF_WADDR      (BUF_WADDR),
      .BUF_WDATA      (BUF_WDATA),
      .RX_STATE_CLEAR (RX_STATE_CLEAR),
      .LVDS_EU        (LVDS_EU),
      .LVDS_EU1_STATE (LVDS_EU1_STATE),
      .LVDS_EU2_STATE (LVDS_EU2_STATE),
      .LVDS_EU3_STATE (LVDS_EU3_STATE),
      .LVDS_EU4_STATE (LVDS_EU4_STATE),
      .EU_WCNT        (EU_WCNT)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   typedef struct {
      logic [3:0]    ack;
      logic [3:0]    we;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   word_t sq [4][$];
   exp_t  exp_q [$];
   logic [3:0] ack_seen = '0;
   int total = 0;
   int bad   = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
      end
   endfunction

   function automatic logic [7:0] st(input int k);
      case (k)
         0:       return LVDS_EU1_STATE;
         1:       return LVDS_EU2_STATE;
         2:       return LVDS_EU3_STATE;
         default: return LVDS_EU4_STATE;
      endcase
   endfunction

   function automatic logic [31:0] wcnt(input int k);
      return 32'(EU_WCNT[k*PW +: PW]);
   endfunction

   // requester model: hold the head word until its ACK, then advance
   initial begin
      EU_WR_REQ  = '0;
      EU_WR_DATA = '0;
      EU_WR_LAST = '0;
      forever begin
         @(posedge HCLK);
         #1;
         for (int k = 0; k < 4; k++) begin
            if (ack_seen[k] && sq[k].size() > 0) sq[k].delete(0);
            if (sq[k].size() > 0) begin
               EU_WR_REQ[k]           = 1'b1;
               EU_WR_DATA[32*k +: 32] = sq[k][0].data;
               EU_WR_LAST[k]          = sq[k][0].last;
            end else begin
               EU_WR_REQ[k]  = 1'b0;
               EU_WR_LAST[k] = 1'b0;
            end
         end
      end
   end

   // monitor: every ACK or write pops one expected transaction
   always @(negedge HCLK) begin
      ack_seen = EU_WR_ACK;
      if (EU_WR_ACK != '0 || BUF_WE != '0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_txn: ack=%b we=%b addr=%0d (t=%0t)", EU_WR_ACK, BUF_WE, BUF_WADDR, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack", 32'(EU_WR_ACK), 32'(e.ack));
            chk("we", 32'(BUF_WE), 32'(e.we));
            if (e.we != '0) begin
               chk("waddr", 32'(BUF_WADDR), 32'(e.addr));
               chk("wdata", BUF_WDATA, e.data);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge HCLK);
      #2;
   endtask

   task automatic push(input int k, input logic [31:0] d, input logic last,
                       input logic wr, input int addr);
      word_t w;
      exp_t  e;
      w.data = d;
      w.last = last;
      sq[k].push_back(w);
      e.ack  = 4'(1 << k);
      e.we   = wr ? 4'(1 << k) : 4'b0000;
      e.addr = AW'(addr);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size() + exp_q.size()) != 0
             && n < 3000) begin
         cyc(1);
         n++;
      end
      chk("drain_timeout", 32'(n >= 3000), 32'd0);
      cyc(2);
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      cyc(2);
      HRESET = 1'b0;
      cyc(1);
   endtask

   task automatic clear(input logic [3:0] sel, input int n);
      RX_STATE_CLEAR = 1'b1;
      LVDS_EU        = sel;
      cyc(n);
      RX_STATE_CLEAR = 1'b0;
      LVDS_EU        = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_we"}, 32'(BUF_WE), 32'd0);
      chk({tag, "_ack"}, 32'(EU_WR_ACK), 32'd0);
      chk({tag, "_waddr"}, 32'(BUF_WADDR), 32'd0);
      chk({tag, "_wdata"}, BUF_WDATA, 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_state%0d", tag, k + 1), 32'(st(k)), 32'h00);
         chk($sformatf("%s_wcnt%0d", tag, k + 1), wcnt(k), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET         = 1'b1;
      RX_STATE_CLEAR = 1'b0;
      LVDS_EU        = '0;
      cyc(3);
      HRESET = 1'b0;
      cyc(1);
      check_reset_vals("rst");

      // EU2 frame of three words
      push(1, 32'h2000_0001, 1'b0, 1'b1, 0);
      push(1, 32'h2000_0002, 1'b0, 1'b1, 1);
      push(1, 32'h2000_0003, 1'b1, 1'b1, 2);
      wait_idle();
      chk("eu2_state", 32'(LVDS_EU2_STATE), 32'h01);
      chk("eu2_wcnt", wcnt(1), 32'd3);

      // all four EUs: strict EU1..EU4 rotation from a fresh last_grant
      do_reset();
      for (int w = 0; w < 4; w++)
         for (int k = 0; k < 4; k++)
            push(k, 32'hA000_0000 | (k << 16) | w, 1'b0, 1'b1, w);
      wait_idle();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_wcnt%0d", k + 1), wcnt(k), 32'd4);
         chk($sformatf("rr_state%0d", k + 1), 32'(st(k)), 32'h04);
      end

      // multi-EU clear, and a clear with no EU selected
      clear(4'b0011, 1);
      chk("mclr_state1", 32'(LVDS_EU1_STATE), 32'h00);
      chk("mclr_wcnt2", wcnt(1), 32'd0);
      chk("mclr_wcnt3", wcnt(2), 32'd4);
      clear(4'b0000, 1);
      chk("noclr_wcnt4", wcnt(3), 32'd4);
      chk("noclr_state4", 32'(LVDS_EU4_STATE), 32'h04);

      // EU3 fills the whole buffer, then LAST arrives on a full buffer
      clear(4'b0100, 1);
      chk("eu3_clr_wcnt", wcnt(2), 32'd0);
      for (int i = 0; i < 512; i++)
         push(2, 32'hC000_0000 | i, 1'b0, 1'b1, i);
      push(2, 32'hC000_0200, 1'b1, 1'b0, 0);
      wait_idle();
      chk("eu3_full_state", 32'(LVDS_EU3_STATE), 32'h03);
      chk("eu3_full_wcnt", wcnt(2), 32'd512);
      chk("waddr_hold", 32'(BUF_WADDR), 32'd511);

      // EU1: frame done, extra word overflows, then a two-cycle clear
      push(0, 32'h1000_0000, 1'b1, 1'b1, 0);
      wait_idle();
      chk("eu1_done_state", 32'(LVDS_EU1_STATE), 32'h01);
      push(0, 32'h1000_0001, 1'b0, 1'b0, 0);
      wait_idle();
      chk("eu1_ovf_state", 32'(LVDS_EU1_STATE), 32'h03);
      chk("eu1_ovf_wcnt", wcnt(0), 32'd1);
      clear(4'b0001, 2);
      chk("eu1_clr_state", 32'(LVDS_EU1_STATE), 32'h00);
      chk("eu1_clr_wcnt", wcnt(0), 32'd0);
      chk("eu3_untouched", 32'(LVDS_EU3_STATE), 32'h03);
      push(0, 32'h1000_0002, 1'b0, 1'b1, 0);
      wait_idle();
      chk("eu1_busy_state", 32'(LVDS_EU1_STATE), 32'h04);

      // EU4 request in the same cycle as its clear
      push(3, 32'h4000_0000, 1'b0, 1'b1, 0);
      cyc(1);
      RX_STATE_CLEAR = 1'b1;
      LVDS_EU        = 4'b1000;
      cyc(1);
      RX_STATE_CLEAR = 1'b0;
      LVDS_EU        = '0;
      chk("eu4_clr_no_ack", 32'(EU_WR_ACK), 32'd0);
      chk("eu4_clr_state", 32'(LVDS_EU4_STATE), 32'h00);
      wait_idle();
      chk("eu4_after_wcnt", wcnt(3), 32'd1);
      chk("eu4_after_state", 32'(LVDS_EU4_STATE), 32'h04);

      // reset in the arbitration cycle drops the grant
      begin
         word_t w;
         w.data = 32'h1000_00FF;
         w.last = 1'b0;
         sq[0].push_back(w);
      end
      cyc(1);
      HRESET = 1'b1;
      sq[0].delete();
      cyc(1);
      chk("rst_drop_we", 32'(BUF_WE), 32'd0);
      chk("rst_drop_ack", 32'(EU_WR_ACK), 32'd0);
      cyc(1);
      HRESET = 1'b0;
      cyc(1);
      check_reset_vals("rst2");
      cyc(2);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
